// File: rtl/tcm_arb_pkg.sv
// Shared types and bus widths for the TCM Wishbone arbiter.
package tcm_arb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef enum logic {
    GNT_M0,
    GNT_M1
  } grant_e;

  // One captured Wishbone request, held stable for the whole TCM transfer.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_DATA_W-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/tcm_arb_pick.sv
// Two-way request picker: round-robin against the last completed owner, or m1-first.
module tcm_arb_pick
  import tcm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last,
  input  logic       rr_en,
  output grant_e     winner
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves winner unassigned (no latch).
    winner = GNT_M0;
    if (req == 2'b11) begin
      winner = (rr_en && last == GNT_M1) ? GNT_M0 : GNT_M1;
    end else if (req[1]) begin
      winner = GNT_M1;
    end
  end

endmodule

// File: rtl/tcm_wb_arbiter.sv
// Two-master Wishbone classic arbiter in front of the single-port TCM: one registered
// transfer at a time, one-cycle strobe, ack/rdata routed back, watchdog error on hang.
module tcm_wb_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit PRIORITY_RR    = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [WB_ADDR_W-1:0] i_m0_addr,
  input  logic                 i_m0_cyc,
  input  logic                 i_m0_stb,
  input  logic                 i_m0_we,
  input  logic [WB_SEL_W-1:0]  i_m0_sel,
  input  logic [WB_DATA_W-1:0] i_m0_wdata,
  output logic                 o_m0_ack,
  output logic                 o_m0_err,
  output logic [WB_DATA_W-1:0] o_m0_rdata,
  input  logic [WB_ADDR_W-1:0] i_m1_addr,
  input  logic                 i_m1_cyc,
  input  logic                 i_m1_stb,
  input  logic                 i_m1_we,
  input  logic [WB_SEL_W-1:0]  i_m1_sel,
  input  logic [WB_DATA_W-1:0] i_m1_wdata,
  output logic                 o_m1_ack,
  output logic                 o_m1_err,
  output logic [WB_DATA_W-1:0] o_m1_rdata,
  output logic [WB_ADDR_W-1:0] o_s_addr,
  output logic                 o_s_cyc,
  output logic                 o_s_stb,
  output logic                 o_s_we,
  output logic [WB_SEL_W-1:0]  o_s_sel,
  output logic [WB_DATA_W-1:0] o_s_wdata,
  input  logic                 i_s_ack,
  input  logic [WB_DATA_W-1:0] i_s_rdata
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e           state, state_nxt;
  grant_e           grant, last, winner;
  wb_req_t          req_q, m0_req, m1_req;
  logic [TMR_W-1:0] timer;
  logic [1:0]       req;
  logic             start, in_wait, gnt_cyc, abort, ack_fwd, tmo;

  assign req     = {i_m1_cyc & i_m1_stb, i_m0_cyc & i_m0_stb};
  assign m0_req  = '{addr: i_m0_addr, we: i_m0_we, sel: i_m0_sel, wdata: i_m0_wdata};
  assign m1_req  = '{addr: i_m1_addr, we: i_m1_we, sel: i_m1_sel, wdata: i_m1_wdata};
  assign start   = (state == IDLE) && (req != 2'b00);
  assign in_wait = (state == WAIT);
  assign gnt_cyc = (grant == GNT_M1) ? i_m1_cyc : i_m0_cyc;

  // Abort beats ack, ack beats timeout; acks outside WAIT never reach a master.
  assign abort   = in_wait && !gnt_cyc;
  assign ack_fwd = in_wait && gnt_cyc && i_s_ack;
  assign tmo     = in_wait && gnt_cyc && !i_s_ack && (timer == TMR_LAST);

  tcm_arb_pick u_pick (
    .req    (req),
    .last   (last),
    .rr_en  (PRIORITY_RR),
    .winner (winner)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (abort || ack_fwd || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture, owner tracking and the saturating watchdog.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      grant <= GNT_M0;
      last  <= GNT_M0;
      req_q <= '0;
      timer <= '0;
    end else begin
      if (start) begin
        grant <= winner;
        req_q <= (winner == GNT_M1) ? m1_req : m0_req;
      end
      if (state == ISSUE) begin
        timer <= '0;
      end else if (in_wait && timer != TMR_LAST) begin
        timer <= timer + 1'b1;
      end
      // Only a completed transfer counts as a turn for round-robin.
      if (ack_fwd) begin
        last <= grant;
      end
    end
  end

  always_comb begin
    o_s_cyc   = 1'b0;
    o_s_stb   = 1'b0;
    o_s_we    = 1'b0;
    o_s_sel   = '0;
    o_s_addr  = '0;
    o_s_wdata = '0;
    if (state == ISSUE || state == WAIT) begin
      o_s_cyc   = 1'b1;
      o_s_stb   = (state == ISSUE);
      o_s_we    = req_q.we;
      o_s_sel   = req_q.sel;
      o_s_addr  = req_q.addr;
      o_s_wdata = req_q.wdata;
    end

    o_m0_ack   = ack_fwd && (grant == GNT_M0);
    o_m1_ack   = ack_fwd && (grant == GNT_M1);
    o_m0_err   = tmo && (grant == GNT_M0);
    o_m1_err   = tmo && (grant == GNT_M1);
    o_m0_rdata = o_m0_ack ? i_s_rdata : '0;
    o_m1_rdata = o_m1_ack ? i_s_rdata : '0;
  end

endmodule
